// File: rtl/ixc_mdr_on_vec.sv
// ixc_mdr_on_vec: multi-channel drive-on change detector with edge filter,
// sticky overflow, saturating event count and a round-robin event slot.
module ixc_mdr_on_vec #(
   parameter int N_CH      = 4,
   parameter int EDGE_MODE = 0,
   parameter int CNT_W     = 8,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             fclk,
   input  logic             rst,
   input  logic [N_CH-1:0]  en,
   output logic [N_CH-1:0]  drOn,
   output logic [N_CH-1:0]  enNxt,
   output logic             evt_valid,
   output logic [CH_W-1:0]  evt_ch,
   output logic             evt_level,
   input  logic             evt_ready,
   output logic [N_CH-1:0]  ovf,
   input  logic [N_CH-1:0]  ovf_clr,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam int PC_W  = $clog2(N_CH + 1);
   localparam int SUM_W = CNT_W + PC_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [N_CH-1:0]  enD;
   logic [N_CH-1:0]  pending;
   logic [N_CH-1:0]  lvl;
   logic [N_CH-1:0]  chg;
   logic [N_CH-1:0]  rise;
   logic [N_CH-1:0]  fall;
   logic [N_CH-1:0]  q;
   logic [N_CH-1:0]  loadMask;
   logic [CH_W-1:0]  rrPtr;
   logic [CH_W-1:0]  selCh;
   logic [CH_W-1:0]  rrNxt;
   logic             found;
   logic             load;
   logic [PC_W-1:0]  popCnt;
   logic [SUM_W-1:0] cntSum;
   logic [CNT_W-1:0] cntNxt;
   int               scanIdx;

   assign chg   = en ^ enD;
   assign rise  = chg & en;
   assign fall  = chg & ~en;
   assign q     = (EDGE_MODE == 1) ? rise :
                  (EDGE_MODE == 2) ? fall : chg;
   assign drOn  = q;
   assign enNxt = ~en;

   // First pending channel at or after rrPtr, wrapping.
   always_comb begin
      selCh   = '0;
      found   = 1'b0;
      scanIdx = 0;
      for (int k = 0; k < N_CH; k++) begin
         scanIdx = (int'(rrPtr) + k) % N_CH;
         if (!found && pending[scanIdx]) begin
            found = 1'b1;
            selCh = CH_W'(scanIdx);
         end
      end
   end

   assign load     = found && (!evt_valid || evt_ready);
   assign loadMask = load ? (N_CH'(1) << selCh) : '0;
   assign rrNxt    = (int'(selCh) == N_CH - 1) ? '0 : selCh + 1'b1;

   always_comb begin
      popCnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         popCnt = popCnt + PC_W'(q[i]);
      end
      cntSum = SUM_W'(evt_cnt) + SUM_W'(popCnt);
      cntNxt = (cntSum > SUM_W'(CNT_MAX)) ? CNT_MAX : cntSum[CNT_W-1:0];
   end

   // enD follows en even in reset so release never yields a spurious change.
   always_ff @(posedge fclk) begin
      enD <= en;
      if (rst) begin
         pending   <= '0;
         lvl       <= '0;
         ovf       <= '0;
         evt_cnt   <= '0;
         evt_valid <= 1'b0;
         evt_ch    <= '0;
         evt_level <= 1'b0;
         rrPtr     <= '0;
      end else begin
         pending <= (pending & ~loadMask) | q;
         lvl     <= (lvl & ~q) | (en & q);
         ovf     <= (ovf & ~ovf_clr) | (q & pending & ~loadMask);
         evt_cnt <= cntNxt;
         if (load) begin
            evt_valid <= 1'b1;
            evt_ch    <= selCh;
            evt_level <= lvl[selCh];
            rrPtr     <= rrNxt;
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ixc_mdr_on_vec.sv
// tb_ixc_mdr_on_vec: directed vectors for ixc_mdr_on_vec in
// both-edge, rising-only and narrow-counter configurations.
module tb_ixc_mdr_on_vec;

   logic fclk;
   int   errs;
   int   checks;

   logic       rstA, validA, levelA, readyA;
   logic [3:0] enA, drOnA, enNxtA, ovfA, ovfClrA;
   logic [1:0] chA;
   logic [7:0] cntA;

   logic       rstB, validB, levelB, readyB;
   logic [3:0] enB, drOnB, enNxtB, ovfB, ovfClrB;
   logic [1:0] chB;
   logic [7:0] cntB;

   logic       rstC, validC, levelC, readyC;
   logic [3:0] enC, drOnC, enNxtC, ovfC, ovfClrC;
   logic [1:0] chC;
   logic [1:0] cntC;

   ixc_mdr_on_vec #(.N_CH(4), .EDGE_MODE(0), .CNT_W(8)) dutA (
      .fclk(fclk), .rst(rstA), .en(enA), .drOn(drOnA), .enNxt(enNxtA),
      .evt_valid(validA), .evt_ch(chA), .evt_level(levelA),
      .evt_ready(readyA), .ovf(ovfA), .ovf_clr(ovfClrA), .evt_cnt(cntA)
   );

   ixc_mdr_on_vec #(.N_CH(4), .EDGE_MODE(1), .CNT_W(8)) dutB (
      .fclk(fclk), .rst(rstB), .en(enB), .drOn(drOnB), .enNxt(enNxtB),
      .evt_valid(validB), .evt_ch(chB), .evt_level(levelB),
      .evt_ready(readyB), .ovf(ovfB), .ovf_clr(ovfClrB), .evt_cnt(cntB)
   );

   ixc_mdr_on_vec #(.N_CH(4), .EDGE_MODE(0), .CNT_W(2)) dutC (
      .fclk(fclk), .rst(rstC), .en(enC), .drOn(drOnC), .enNxt(enNxtC),
      .evt_valid(validC), .evt_ch(chC), .evt_level(levelC),
      .evt_ready(readyC), .ovf(ovfC), .ovf_clr(ovfClrC), .evt_cnt(cntC)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rstA = 1'b1; enA = 4'b1010; readyA = 1'b1; ovfClrA = '0;
      rstB = 1'b1; enB = 4'b0000; readyB = 1'b1; ovfClrB = '0;
      rstC = 1'b1; enC = 4'b0000; readyC = 1'b0; ovfClrC = '0;

      // T1 reset hold
      tick();
      tick();
      chk("t1 drOn in rst", drOnA, 4'b0000);
      rstA = 1'b0;
      chk("t1 enNxt", enNxtA, 4'b0101);
      chk("t1 ovf", ovfA, 4'b0000);
      chk("t1 ch", chA, 2'd0);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t1 drOn", drOnA, 4'b0000);
         chk("t1 valid", validA, 1'b0);
         chk("t1 cnt", cntA, 8'd0);
         tick();
      end

      // T2 single rising change on ch2
      enA = 4'b1110;
      #1;
      chk("t2 drOn pulse", drOnA, 4'b0100);
      tick();
      chk("t2 drOn gone", drOnA, 4'b0000);
      chk("t2 valid E0", validA, 1'b0);
      chk("t2 cnt", cntA, 8'd1);
      tick();
      chk("t2 valid E1", validA, 1'b1);
      chk("t2 ch", chA, 2'd2);
      chk("t2 level", levelA, 1'b1);
      tick();
      chk("t2 valid drop", validA, 1'b0);

      // T3 round-robin
      rstA = 1'b1;
      enA  = 4'b0000;
      tick();
      rstA = 1'b0;
      chk("t3 cnt after rst", cntA, 8'd0);
      chk("t3 drOn after rst", drOnA, 4'b0000);
      enA = 4'b1111;
      tick();
      chk("t3 cnt 4", cntA, 8'd4);
      chk("t3 valid E0", validA, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t3 rr valid", validA, 1'b1);
         chk("t3 rr ch", chA, k);
         chk("t3 rr level", levelA, 1'b1);
      end
      tick();
      chk("t3 drained", validA, 1'b0);
      enA = 4'b0110;
      tick();
      tick();
      chk("t3 wrap ch0", chA, 2'd0);
      chk("t3 wrap lvl0", levelA, 1'b0);
      tick();
      chk("t3 wrap ch3", chA, 2'd3);
      chk("t3 wrap lvl3", levelA, 1'b0);
      tick();
      chk("t3 wrap drained", validA, 1'b0);
      chk("t3 cnt 6", cntA, 8'd6);

      // T4 backpressure and overflow
      readyA = 1'b0;
      enA = 4'b0100;
      tick();
      tick();
      chk("t4 valid", validA, 1'b1);
      chk("t4 ch", chA, 2'd1);
      chk("t4 level", levelA, 1'b0);
      enA = 4'b0110;
      tick();
      chk("t4 no ovf yet", ovfA, 4'b0000);
      chk("t4 held ch", chA, 2'd1);
      enA = 4'b0100;
      tick();
      chk("t4 ovf set", ovfA, 4'b0010);
      chk("t4 held ch2", chA, 2'd1);
      chk("t4 held lvl", levelA, 1'b0);
      chk("t4 held valid", validA, 1'b1);
      enA = 4'b0110;
      ovfClrA = 4'b0010;
      tick();
      chk("t4 set beats clr", ovfA, 4'b0010);
      tick();
      chk("t4 clr", ovfA, 4'b0000);
      ovfClrA = 4'b0000;
      readyA = 1'b1;
      tick();
      chk("t4 next valid", validA, 1'b1);
      chk("t4 next ch", chA, 2'd1);
      chk("t4 latest lvl", levelA, 1'b1);
      tick();
      chk("t4 drained", validA, 1'b0);
      chk("t4 cnt", cntA, 8'd10);

      // T5 rising-only filter
      rstB = 1'b0;
      enB = 4'b0001;
      #1;
      chk("t5 rise pulse", drOnB, 4'b0001);
      tick();
      enB = 4'b0000;
      #1;
      chk("t5 fall masked", drOnB, 4'b0000);
      tick();
      chk("t5 valid", validB, 1'b1);
      chk("t5 ch", chB, 2'd0);
      chk("t5 level", levelB, 1'b1);
      tick();
      chk("t5 one event", validB, 1'b0);
      chk("t5 cnt", cntB, 8'd1);
      tick();
      chk("t5 cnt held", cntB, 8'd1);

      // T6 saturation and reset mid-queue
      rstC = 1'b0;
      for (int t = 0; t < 5; t++) begin
         enC[0] = ~enC[0];
         tick();
      end
      chk("t6 cnt sat", cntC, 2'd3);
      chk("t6 valid", validC, 1'b1);
      chk("t6 ovf", ovfC, 4'b0001);
      tick();
      chk("t6 cnt held", cntC, 2'd3);
      rstC = 1'b1;
      tick();
      chk("t6 rst valid", validC, 1'b0);
      chk("t6 rst cnt", cntC, 2'd0);
      chk("t6 rst ovf", ovfC, 4'b0000);
      rstC = 1'b0;
      tick();
      tick();
      chk("t6 pend cleared", validC, 1'b0);
      chk("t6 cnt stays 0", cntC, 2'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
